// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - op classes, opcodes and decoded record for the RV32I decode stage (DECODE_ILLEGAL_EN adds illegal flag)
package decode_pkg;

  localparam logic [2:0] OPC_NOP    = 3'd0;
  localparam logic [2:0] OPC_ALU    = 3'd1;
  localparam logic [2:0] OPC_BRANCH = 3'd2;
  localparam logic [2:0] OPC_LOAD   = 3'd3;
  localparam logic [2:0] OPC_STORE  = 3'd4;
  localparam logic [2:0] OPC_JAL    = 3'd5;
  localparam logic [2:0] OPC_JALR   = 3'd6;
  localparam logic [2:0] OPC_UPPER  = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Immediate is kept at 32 bits inside the buffers and widened at the output.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  op_class;
    logic        use_imm;
    logic [31:0] imm;
    logic        arith_mode;
    logic        logic_alt;
    logic [2:0]  funct3;
    logic        lt;
    logic        invert_comparison;
    logic        unsigned_comparison;
`ifdef DECODE_ILLEGAL_EN
    logic        illegal;
`endif
  } decoded_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/decode_if.sv
// rtl/decode_if.sv - fetch-side and execute-side handshake bundle of the decode stage (DECODE_ILLEGAL_EN adds out_illegal)
interface decode_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_insn;
  logic [WIDTH-1:0] in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [2:0]       out_op_class;
  logic             out_use_imm;
  logic [WIDTH-1:0] out_imm;
  logic             out_arith_mode;
  logic             out_logic_alt;
  logic [2:0]       out_funct3;
  logic             out_lt;
  logic             out_invert_comparison;
  logic             out_unsigned_comparison;
`ifdef DECODE_ILLEGAL_EN
  logic             out_illegal;
`endif

  // Decode stage side
  modport slave (
    input  in_valid, in_insn, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_op_class,
           out_use_imm, out_imm, out_arith_mode, out_logic_alt, out_funct3, out_lt,
           out_invert_comparison, out_unsigned_comparison
`ifdef DECODE_ILLEGAL_EN
           , out_illegal
`endif
  );

  // Fetch/execute side
  modport master (
    output in_valid, in_insn, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_op_class,
           out_use_imm, out_imm, out_arith_mode, out_logic_alt, out_funct3, out_lt,
           out_invert_comparison, out_unsigned_comparison
`ifdef DECODE_ILLEGAL_EN
           , out_illegal
`endif
  );

endinterface

// File: rtl/decode_logic.sv
// rtl/decode_logic.sv - combinational RV32I instruction to decoded_t translation (DECODE_ILLEGAL_EN flags bad encodings)
module decode_logic
  import decode_pkg::*;
(
  input  logic [31:0] insn_i,
  output decoded_t    dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = insn_i[6:0];
  assign f3     = insn_i[14:12];
  assign f7     = insn_i[31:25];

  assign imm_i = {{20{insn_i[31]}}, insn_i[31:20]};
  assign imm_s = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
  assign imm_b = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
  assign imm_u = {insn_i[31:12], 12'h000};
  assign imm_j = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};

  // Classify the opcode and fill control fields; anything not decodable collapses to a NOP record.
  always_comb begin
    logic bad;
    dec_o     = '0;
    bad       = 1'b0;
    dec_o.rs1 = insn_i[19:15];
    dec_o.rs2 = insn_i[24:20];
    dec_o.rd  = insn_i[11:7];
    unique case (opcode)
      OP_OP: begin
        dec_o.op_class   = OPC_ALU;
        dec_o.funct3     = f3;
        dec_o.logic_alt  = insn_i[30];
        dec_o.arith_mode = insn_i[30] && (f3 == 3'b000);
        if (f3 == 3'b010 || f3 == 3'b011) begin
          dec_o.lt                  = 1'b1;
          dec_o.unsigned_comparison = f3[0];
        end
        bad = !((f7 == F7_ZERO) || ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_OPIMM: begin
        dec_o.op_class  = OPC_ALU;
        dec_o.use_imm   = 1'b1;
        dec_o.imm       = imm_i;
        dec_o.funct3    = f3;
        dec_o.logic_alt = insn_i[30] && (f3 == 3'b101);
        if (f3 == 3'b010 || f3 == 3'b011) begin
          dec_o.lt                  = 1'b1;
          dec_o.unsigned_comparison = f3[0];
        end
        if (f3 == 3'b001) bad = (f7 != F7_ZERO);
        if (f3 == 3'b101) bad = !((f7 == F7_ZERO) || (f7 == F7_ALT));
      end
      OP_BRANCH: begin
        dec_o.op_class            = OPC_BRANCH;
        dec_o.rd                  = 5'd0;
        dec_o.imm                 = imm_b;
        dec_o.funct3              = f3;
        dec_o.lt                  = f3[2];
        dec_o.invert_comparison   = f3[0];
        dec_o.unsigned_comparison = f3[1];
      end
      OP_LOAD: begin
        dec_o.op_class = OPC_LOAD;
        dec_o.use_imm  = 1'b1;
        dec_o.imm      = imm_i;
        dec_o.funct3   = f3;
      end
      OP_STORE: begin
        dec_o.op_class = OPC_STORE;
        dec_o.rd       = 5'd0;
        dec_o.use_imm  = 1'b1;
        dec_o.imm      = imm_s;
        dec_o.funct3   = f3;
      end
      OP_JALR: begin
        dec_o.op_class = OPC_JALR;
        dec_o.use_imm  = 1'b1;
        dec_o.imm      = imm_i;
      end
      OP_JAL: begin
        dec_o.op_class = OPC_JAL;
        dec_o.use_imm  = 1'b1;
        dec_o.imm      = imm_j;
      end
      OP_LUI, OP_AUIPC: begin
        dec_o.op_class = OPC_UPPER;
        dec_o.use_imm  = 1'b1;
        dec_o.imm      = imm_u;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec_o = '0;
`ifdef DECODE_ILLEGAL_EN
      dec_o.illegal = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with 2-entry skid buffer (DECODE_ILLEGAL_EN drives out_illegal)
module decode_stage
  import decode_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  decode_if.slave   bus
);

  skid_state_e      state_q, state_d;
  decoded_t         main_q, main_d;
  decoded_t         skid_q, skid_d;
  logic [WIDTH-1:0] main_pc_q, main_pc_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  decoded_t         dec;
  logic             accept;
  logic             retire;
  logic [WIDTH-1:0] imm_ext;

  decode_logic u_decode_logic (
    .insn_i (bus.in_insn),
    .dec_o  (dec)
  );

  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign accept        = bus.in_valid && bus.in_ready;
  assign retire        = bus.out_valid && bus.out_ready;

  // Skid control: choose next occupancy and which entry loads; flush overrides any handshake.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    main_pc_d = main_pc_q;
    skid_pc_d = skid_pc_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_d    = dec;
            main_pc_d = bus.in_pc;
          end
        end
        ST_ONE: begin
          if (accept && !retire) begin
            state_d   = ST_FULL;
            skid_d    = dec;
            skid_pc_d = bus.in_pc;
          end else if (accept && retire) begin
            main_d    = dec;
            main_pc_d = bus.in_pc;
          end else if (retire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (retire) begin
            state_d   = ST_ONE;
            main_d    = skid_q;
            main_pc_d = skid_pc_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Entry payload registers; cleared on reset so the outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q    <= '0;
      skid_q    <= '0;
      main_pc_q <= '0;
      skid_pc_q <= '0;
    end else begin
      main_q    <= main_d;
      skid_q    <= skid_d;
      main_pc_q <= main_pc_d;
      skid_pc_q <= skid_pc_d;
    end
  end

  // Widen the 32-bit immediate to the datapath width by sign extension.
  always_comb begin
    imm_ext       = {WIDTH{main_q.imm[31]}};
    imm_ext[31:0] = main_q.imm;
  end

  assign bus.out_pc                  = main_pc_q;
  assign bus.out_rs1                 = main_q.rs1;
  assign bus.out_rs2                 = main_q.rs2;
  assign bus.out_rd                  = main_q.rd;
  assign bus.out_op_class            = main_q.op_class;
  assign bus.out_use_imm             = main_q.use_imm;
  assign bus.out_imm                 = imm_ext;
  assign bus.out_arith_mode          = main_q.arith_mode;
  assign bus.out_logic_alt           = main_q.logic_alt;
  assign bus.out_funct3              = main_q.funct3;
  assign bus.out_lt                  = main_q.lt;
  assign bus.out_invert_comparison   = main_q.invert_comparison;
  assign bus.out_unsigned_comparison = main_q.unsigned_comparison;
`ifdef DECODE_ILLEGAL_EN
  assign bus.out_illegal             = main_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage (DECODE_ILLEGAL_EN enables illegal checks)
module tb_decode_stage;
  import decode_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;

  decode_if #(.WIDTH(32)) dif ();

  decode_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick;
    tick;
    checks++;
    if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", dif.out_valid); end
    checks++;
    if (dif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", dif.in_ready); end
    checks++;
    if ({dif.out_imm, dif.out_pc, dif.out_rd, dif.out_op_class} !== '0) begin
      errors++; $display("FAIL reset_data imm=%h pc=%h rd=%0d cls=%0d want 0", dif.out_imm, dif.out_pc, dif.out_rd, dif.out_op_class);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_add_sub;
    dif.out_ready = 1'b1;
    dif.in_valid  = 1'b1;
    dif.in_insn   = 32'h002081B3;
    dif.in_pc     = 32'h0000_0100;
    tick;
    checks++;
    if (dif.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", dif.out_valid); end
    checks++;
    if ({dif.out_rs1, dif.out_rs2, dif.out_rd} !== {5'd1, 5'd2, 5'd3}) begin
      errors++; $display("FAIL add_regs got %0d %0d %0d want 1 2 3", dif.out_rs1, dif.out_rs2, dif.out_rd);
    end
    checks++;
    if ({dif.out_funct3, dif.out_arith_mode, dif.out_use_imm, dif.out_op_class} !== {3'd0, 1'b0, 1'b0, OPC_ALU}) begin
      errors++; $display("FAIL add_ctrl got f3=%0d am=%0b ui=%0b cls=%0d want 0 0 0 1", dif.out_funct3, dif.out_arith_mode, dif.out_use_imm, dif.out_op_class);
    end
    checks++;
    if (dif.out_pc !== 32'h100) begin errors++; $display("FAIL add_pc got %h want 100", dif.out_pc); end
    dif.in_insn = 32'h402081B3;
    dif.in_pc   = 32'h0000_0104;
    tick;
    checks++;
    if ({dif.out_arith_mode, dif.out_logic_alt, dif.out_pc} !== {1'b1, 1'b1, 32'h104}) begin
      errors++; $display("FAIL sub_ctrl got am=%0b la=%0b pc=%h want 1 1 104", dif.out_arith_mode, dif.out_logic_alt, dif.out_pc);
    end
    dif.in_valid = 1'b0;
    tick;
    checks++;
    if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain got %0b want 0", dif.out_valid); end
  endtask

  task automatic test_decode_table;
    logic [31:0] t_insn [6];
    logic [31:0] t_imm  [6];
    logic [2:0]  t_cls  [6];
    logic        t_ui   [6];
    logic [4:0]  t_rs1  [6];
    logic [4:0]  t_rd   [6];
    logic [2:0]  t_f3   [6];
    logic [3:0]  t_cmp  [6];
    // SRAI x5,x6,3
    t_insn[0] = 32'h40335293; t_imm[0] = 32'h00000403; t_cls[0] = OPC_ALU;    t_ui[0] = 1'b1;
    t_rs1[0] = 5'd6; t_rd[0] = 5'd5; t_f3[0] = 3'd5; t_cmp[0] = 4'b0001;
    // BLTU x1,x2,-4
    t_insn[1] = 32'hFE20EEE3; t_imm[1] = 32'hFFFFFFFC; t_cls[1] = OPC_BRANCH; t_ui[1] = 1'b0;
    t_rs1[1] = 5'd1; t_rd[1] = 5'd0; t_f3[1] = 3'd6; t_cmp[1] = 4'b1010;
    // LW x7,-8(x2)
    t_insn[2] = 32'hFF812383; t_imm[2] = 32'hFFFFFFF8; t_cls[2] = OPC_LOAD;   t_ui[2] = 1'b1;
    t_rs1[2] = 5'd2; t_rd[2] = 5'd7; t_f3[2] = 3'd2; t_cmp[2] = 4'b0000;
    // LUI x1,0x12345
    t_insn[3] = 32'h123450B7; t_imm[3] = 32'h12345000; t_cls[3] = OPC_UPPER;  t_ui[3] = 1'b1;
    t_rs1[3] = 5'd8; t_rd[3] = 5'd1; t_f3[3] = 3'd0; t_cmp[3] = 4'b0000;
    // SLTU x4,x5,x6
    t_insn[4] = 32'h0062B233; t_imm[4] = 32'h00000000; t_cls[4] = OPC_ALU;    t_ui[4] = 1'b0;
    t_rs1[4] = 5'd5; t_rd[4] = 5'd4; t_f3[4] = 3'd3; t_cmp[4] = 4'b1010;
    // BGE x1,x2,+8
    t_insn[5] = 32'h0020D463; t_imm[5] = 32'h00000008; t_cls[5] = OPC_BRANCH; t_ui[5] = 1'b0;
    t_rs1[5] = 5'd1; t_rd[5] = 5'd0; t_f3[5] = 3'd5; t_cmp[5] = 4'b1100;
    dif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dif.in_valid = 1'b1;
      dif.in_insn  = t_insn[i];
      dif.in_pc    = 32'h200 + 32'(i * 4);
      tick;
      checks++;
      if ({dif.out_valid, dif.out_op_class, dif.out_use_imm} !== {1'b1, t_cls[i], t_ui[i]}) begin
        errors++; $display("FAIL tbl%0d_class got v=%0b cls=%0d ui=%0b want 1 %0d %0b", i, dif.out_valid, dif.out_op_class, dif.out_use_imm, t_cls[i], t_ui[i]);
      end
      checks++;
      if (dif.out_imm !== t_imm[i]) begin errors++; $display("FAIL tbl%0d_imm got %h want %h", i, dif.out_imm, t_imm[i]); end
      checks++;
      if ({dif.out_rs1, dif.out_rd, dif.out_funct3} !== {t_rs1[i], t_rd[i], t_f3[i]}) begin
        errors++; $display("FAIL tbl%0d_fields got rs1=%0d rd=%0d f3=%0d want %0d %0d %0d", i, dif.out_rs1, dif.out_rd, dif.out_funct3, t_rs1[i], t_rd[i], t_f3[i]);
      end
      checks++;
      if ({dif.out_lt, dif.out_invert_comparison, dif.out_unsigned_comparison, dif.out_logic_alt} !== t_cmp[i]) begin
        errors++; $display("FAIL tbl%0d_cmp got %b%b%b%b want %b", i, dif.out_lt, dif.out_invert_comparison, dif.out_unsigned_comparison, dif.out_logic_alt, t_cmp[i]);
      end
    end
    dif.in_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_pc [3];
    logic [4:0]  exp_rd [3];
    logic        acc;
    exp_pc[0] = 32'h300; exp_pc[1] = 32'h304; exp_pc[2] = 32'h308;
    exp_rd[0] = 5'd3;    exp_rd[1] = 5'd4;    exp_rd[2] = 5'd5;
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b1;
    dif.in_insn   = 32'h002081B3;
    dif.in_pc     = 32'h300;
    tick;
    checks++;
    if ({dif.in_ready, dif.out_valid} !== 2'b11) begin errors++; $display("FAIL b2b_after_a got rdy=%0b v=%0b want 1 1", dif.in_ready, dif.out_valid); end
    dif.in_insn = 32'h00208233;
    dif.in_pc   = 32'h304;
    tick;
    checks++;
    if (dif.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %0b want 0", dif.in_ready); end
    dif.in_insn = 32'h002082B3;
    dif.in_pc   = 32'h308;
    tick;
    checks++;
    if ({dif.out_pc, dif.in_ready} !== {32'h300, 1'b0}) begin errors++; $display("FAIL b2b_hold got pc=%h rdy=%0b want 300 0", dif.out_pc, dif.in_ready); end
    dif.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dif.out_valid, dif.out_pc, dif.out_rd} !== {1'b1, exp_pc[k], exp_rd[k]}) begin
        errors++; $display("FAIL b2b_order%0d got v=%0b pc=%h rd=%0d want 1 %h %0d", k, dif.out_valid, dif.out_pc, dif.out_rd, exp_pc[k], exp_rd[k]);
      end
      acc = dif.in_valid && dif.in_ready;
      tick;
      if (acc) dif.in_valid = 1'b0;
    end
    checks++;
    if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", dif.out_valid); end
  endtask

  task automatic fill_full;
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b1;
    dif.in_insn   = 32'h002081B3;
    dif.in_pc     = 32'h400;
    tick;
    dif.in_pc     = 32'h404;
    tick;
    dif.in_pc     = 32'h408;
  endtask

  task automatic test_flush;
    fill_full;
    checks++;
    if (dif.in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull got %0b want 0", dif.in_ready); end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    dif.in_valid = 1'b0;
    checks++;
    if ({dif.out_valid, dif.in_ready} !== 2'b01) begin errors++; $display("FAIL flush_full got v=%0b rdy=%0b want 0 1", dif.out_valid, dif.in_ready); end
    // flush while ONE with a completing accept: the incoming entry is dropped too
    dif.in_valid = 1'b1;
    dif.in_pc    = 32'h500;
    tick;
    dif.in_pc    = 32'h504;
    flush        = 1'b1;
    tick;
    flush        = 1'b0;
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b1;
    tick;
    checks++;
    if ({dif.out_valid, dif.in_ready} !== 2'b01) begin errors++; $display("FAIL flush_one got v=%0b rdy=%0b want 0 1", dif.out_valid, dif.in_ready); end
  endtask

  task automatic test_reset_midstream;
    fill_full;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dif.out_valid, dif.in_ready, dif.out_pc} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL rst_mid got v=%0b rdy=%0b pc=%h want 0 1 0", dif.out_valid, dif.in_ready, dif.out_pc);
    end
    dif.in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    dif.out_ready = 1'b1;
    tick;
    tick;
    checks++;
    if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_replay got %0b want 0", dif.out_valid); end
  endtask

  task automatic test_illegal;
    dif.out_ready = 1'b1;
    dif.in_valid  = 1'b1;
    dif.in_insn   = 32'h00000000;
    dif.in_pc     = 32'h600;
    tick;
    checks++;
    if ({dif.out_valid, dif.out_op_class, dif.out_imm} !== {1'b1, OPC_NOP, 32'h0}) begin
      errors++; $display("FAIL zero_nop got v=%0b cls=%0d imm=%h want 1 0 0", dif.out_valid, dif.out_op_class, dif.out_imm);
    end
`ifdef DECODE_ILLEGAL_EN
    checks++;
    if (dif.out_illegal !== 1'b1) begin errors++; $display("FAIL ill_zero got %0b want 1", dif.out_illegal); end
`endif
    dif.in_insn = 32'h022081B3;
    tick;
    checks++;
    if (dif.out_op_class !== OPC_NOP) begin errors++; $display("FAIL ill_f7_cls got %0d want 0", dif.out_op_class); end
`ifdef DECODE_ILLEGAL_EN
    checks++;
    if (dif.out_illegal !== 1'b1) begin errors++; $display("FAIL ill_f7 got %0b want 1", dif.out_illegal); end
`endif
    dif.in_insn = 32'h002081B3;
    tick;
    checks++;
    if (dif.out_op_class !== OPC_ALU) begin errors++; $display("FAIL ill_add_cls got %0d want 1", dif.out_op_class); end
`ifdef DECODE_ILLEGAL_EN
    checks++;
    if (dif.out_illegal !== 1'b0) begin errors++; $display("FAIL ill_add got %0b want 0", dif.out_illegal); end
`endif
    dif.in_valid = 1'b0;
    tick;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    flush         = 1'b0;
    dif.in_valid  = 1'b0;
    dif.in_insn   = '0;
    dif.in_pc     = '0;
    dif.out_ready = 1'b0;
    test_reset;
    test_add_sub;
    test_decode_table;
    test_back_to_back;
    test_flush;
    test_reset_midstream;
    test_illegal;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
